// File: rtl/multi_freq_monitor.sv
// multi_freq_monitor: per-channel toggle-rate frequency counter with hysteretic mode, range and lock status.
// Define FREQ_MON_IRQ_EN to add I_irq_clr/O_irq and the sticky per-channel event flags.
module multi_freq_monitor #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 16,
  parameter int GATE_CYCLES = 100000,
  parameter int LF_MIN_CNT  = 625,
  parameter int LF_MAX_CNT  = 9378,
  parameter int HF_MIN_CNT  = 9371,
  parameter int HF_MAX_CNT  = 31312,
  parameter int LOCK_TOL    = 2,
  parameter int LOCK_CNT    = 4
) (
  input  logic                    I_ref_clk,
  input  logic                    I_reset_n,
  input  logic [NUM_CH-1:0]       I_tog,
  input  logic                    I_restart,
`ifdef FREQ_MON_IRQ_EN
  input  logic                    I_irq_clr,
  output logic                    O_irq,
`endif
  output logic [NUM_CH*CNT_W-1:0] O_freq_word,
  output logic [NUM_CH-1:0]       O_freq_mode,
  output logic [NUM_CH-1:0]       O_freq_or,
  output logic [NUM_CH-1:0]       O_locked,
  output logic                    O_freq_set
);
  localparam int GW = $clog2(GATE_CYCLES);
  localparam int SW = $clog2(LOCK_CNT + 1);
  typedef enum logic [1:0] {IDLE, ACQ, LOCKED} state_t;
  logic [1:0] rst_sync_q;
  logic rst_n;
  logic [GW-1:0] gate_q, gate_d;
  logic term, close, set_q;
  logic [NUM_CH-1:0] s1_q, s2_q, s3_q, tg_edge;
  // Reset asserts immediately but releases only after two clean clock edges.
  always_ff @(posedge I_ref_clk or negedge I_reset_n)
    if (!I_reset_n) rst_sync_q <= '0;
    else rst_sync_q <= {rst_sync_q[0], 1'b1};
  assign rst_n = rst_sync_q[1];
  always_comb begin
    term    = gate_q == GW'(GATE_CYCLES - 1);
    close   = term && !I_restart;
    gate_d  = (I_restart || term) ? '0 : gate_q + GW'(1);
    tg_edge = s2_q ^ s3_q;
  end
  always_ff @(posedge I_ref_clk or negedge rst_n)
    if (!rst_n) begin
      gate_q <= '0;
      set_q  <= 1'b0;
      s1_q   <= '0;
      s2_q   <= '0;
      s3_q   <= '0;
    end else begin
      gate_q <= gate_d;
      set_q  <= close;
      s1_q   <= I_tog;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
    end
  assign O_freq_set = set_q;
`ifdef FREQ_MON_IRQ_EN
  logic [NUM_CH-1:0] flag_w;
  assign O_irq = |flag_w;
`endif
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d, win, word_q, word_d, prev_q, prev_d;
    logic [CNT_W:0] delta;
    logic [31:0] w32;
    logic mode_q, mode_d, or_q, or_d, rng, stable;
    logic [SW-1:0] stab_q, stab_d;
    state_t st_q, st_d;
    always_comb begin
      win    = (tg_edge[k] && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
      w32    = 32'(win);
      rng    = w32 < 32'(LF_MIN_CNT) || w32 > 32'(HF_MAX_CNT) || (&win);
      delta  = (win >= prev_q) ? {1'b0, win} - {1'b0, prev_q} : {1'b0, prev_q} - {1'b0, win};
      stable = !rng && 32'(delta) <= 32'(LOCK_TOL);
      cnt_d  = (I_restart || term) ? '0 : win;
      word_d = close ? win : word_q;
      prev_d = close ? win : prev_q;
      or_d   = close ? rng : or_q;
      mode_d = !close ? mode_q : w32 > 32'(LF_MAX_CNT) ? 1'b1 : w32 < 32'(HF_MIN_CNT) ? 1'b0 : mode_q;
      st_d   = st_q;
      stab_d = stab_q;
      if (I_restart) begin
        st_d   = IDLE;
        stab_d = '0;
      end else if (close && (st_q == IDLE || !stable)) begin
        st_d   = ACQ;
        stab_d = '0;
      end else if (close && st_q == ACQ) begin
        stab_d = stab_q + SW'(1);
        st_d   = 32'(stab_d) >= 32'(LOCK_CNT) ? LOCKED : ACQ;
      end
    end
    always_ff @(posedge I_ref_clk or negedge rst_n)
      if (!rst_n) begin
        cnt_q  <= '0;
        word_q <= '0;
        prev_q <= '0;
        mode_q <= 1'b0;
        or_q   <= 1'b0;
        stab_q <= '0;
        st_q   <= IDLE;
      end else begin
        cnt_q  <= cnt_d;
        word_q <= word_d;
        prev_q <= prev_d;
        mode_q <= mode_d;
        or_q   <= or_d;
        stab_q <= stab_d;
        st_q   <= st_d;
      end
    assign O_freq_word[k*CNT_W +: CNT_W] = word_q;
    assign O_freq_mode[k] = mode_q;
    assign O_freq_or[k]   = or_q;
    assign O_locked[k]    = st_q == LOCKED;
`ifdef FREQ_MON_IRQ_EN
    logic flag_q, flag_d;
    // Only window-close events raise a flag; a set on the same edge beats a clear.
    always_comb
      flag_d = (close && ((st_q == LOCKED && st_d != LOCKED) || (!or_q && or_d))) ? 1'b1 :
               I_irq_clr ? 1'b0 : flag_q;
    always_ff @(posedge I_ref_clk or negedge rst_n)
      if (!rst_n) flag_q <= 1'b0;
      else flag_q <= flag_d;
    assign flag_w[k] = flag_q;
`endif
  end
endmodule

// File: tb/tb_multi_freq_monitor.sv
// tb_multi_freq_monitor: table-driven per-gate vectors plus restart, saturation, reset and IRQ sequences.
module tb_multi_freq_monitor;
  logic clk = 1'b0, rst_n = 1'b0, restart = 1'b0, tog3 = 1'b0, ph = 1'b0;
  logic [2:0] tog_lo = '0;
  logic [63:0] word;
  logic [3:0] mode, orr, locked;
  logic fset;
  logic [7:0] word8;
  logic mode8, or8, lock8, set8;
  int checks = 0, failures = 0;
  int ew0 = 0, ew1 = 0, ew2 = 0;
`ifdef FREQ_MON_IRQ_EN
  logic irq_clr = 1'b0, irq, irq8;
  bit irq_test = 1'b0;
`endif

  multi_freq_monitor #(.NUM_CH(4), .CNT_W(16), .GATE_CYCLES(1000), .LF_MIN_CNT(6), .LF_MAX_CNT(94),
    .HF_MIN_CNT(93), .HF_MAX_CNT(313), .LOCK_TOL(2), .LOCK_CNT(4)) dut (
    .I_ref_clk(clk), .I_reset_n(rst_n), .I_tog({tog3, tog_lo}), .I_restart(restart),
`ifdef FREQ_MON_IRQ_EN
    .I_irq_clr(irq_clr), .O_irq(irq),
`endif
    .O_freq_word(word), .O_freq_mode(mode), .O_freq_or(orr), .O_locked(locked), .O_freq_set(fset));

  multi_freq_monitor #(.NUM_CH(1), .CNT_W(8), .GATE_CYCLES(1000), .LF_MIN_CNT(6), .LF_MAX_CNT(94),
    .HF_MIN_CNT(93), .HF_MAX_CNT(313), .LOCK_TOL(2), .LOCK_CNT(4)) dut8 (
    .I_ref_clk(clk), .I_reset_n(rst_n), .I_tog(tog3), .I_restart(restart),
`ifdef FREQ_MON_IRQ_EN
    .I_irq_clr(irq_clr), .O_irq(irq8),
`endif
    .O_freq_word(word8), .O_freq_mode(mode8), .O_freq_or(or8), .O_locked(lock8), .O_freq_set(set8));

  always #5 clk = ~clk;

  // Channel 3 toggles every 2 cycles for the whole run: 500 transitions per gate.
  initial forever begin
    @(negedge clk);
    ph = ~ph;
    if (ph) tog3 = ~tog3;
  end

  typedef struct {
    int n0, n1, n2;
    logic [3:0] mode, orr, lk;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Starts on the negedge where the gate counter reads 0; channel k makes n[k] transitions spaced 3 cycles apart.
  task automatic run_gate(input int n0, input int n1, input int n2, input int rst_at);
    int n[3];
    int spur;
    n = '{n0, n1, n2};
    spur = 0;
    for (int i = 0; i < 1000 && i <= rst_at; i++) begin
      if (i > 0) @(negedge clk);
      if (i > 0 && fset) spur++;
      restart = (i == rst_at);
      for (int k = 0; k < 3; k++)
        if (i >= 8 && i < 8 + 3 * n[k] && (i - 8) % 3 == 0) tog_lo[k] = ~tog_lo[k];
`ifdef FREQ_MON_IRQ_EN
      irq_clr = irq_test && (i == 0 || i == 999);
      if (irq_test && i == 1) chk("irq_clr", {63'b0, irq}, 64'd0);
`endif
    end
    chk("set_spurious", spur, 0);
  endtask

  function automatic logic [63:0] wexp(input int a, input int b, input int c);
    return {16'd500, 16'(c), 16'(b), 16'(a)};
  endfunction

  initial begin
    tbl[0]  = '{50, 50, 200, 4'b1100, 4'b1000, 4'b0000};
    tbl[1]  = '{50, 93, 200, 4'b1100, 4'b1000, 4'b0000};
    tbl[2]  = '{50, 94, 200, 4'b1100, 4'b1000, 4'b0000};
    tbl[3]  = '{50, 95, 200, 4'b1110, 4'b1000, 4'b0000};
    tbl[4]  = '{50, 93, 200, 4'b1110, 4'b1000, 4'b0101};
    tbl[5]  = '{50, 92, 205, 4'b1100, 4'b1000, 4'b0011};
    tbl[6]  = '{50, 92, 205, 4'b1100, 4'b1000, 4'b0011};
    tbl[7]  = '{5,  92, 205, 4'b1100, 4'b1001, 4'b0010};
    tbl[8]  = '{6,  92, 205, 4'b1100, 4'b1000, 4'b0010};
    tbl[9]  = '{6,  92, 205, 4'b1100, 4'b1000, 4'b0110};
    tbl[10] = '{6, 313, 205, 4'b1110, 4'b1000, 4'b0100};
    tbl[11] = '{6, 314, 205, 4'b1110, 4'b1010, 4'b0101};
    repeat (3) @(negedge clk);
    chk("rst_word", word, 64'd0);
    chk("rst_flags", {mode, orr, locked, 3'b0, fset}, 16'd0);
    chk("rst_word8", {word8, mode8, or8, lock8, set8}, 12'd0);
`ifdef FREQ_MON_IRQ_EN
    chk("rst_irq", {62'b0, irq, irq8}, 64'd0);
`endif
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    for (int r = 0; r < 12; r++) begin
      run_gate(tbl[r].n0, tbl[r].n1, tbl[r].n2, 1000);
      @(negedge clk);
      ew0 = tbl[r].n0; ew1 = tbl[r].n1; ew2 = tbl[r].n2;
      chk($sformatf("g%0d_set", r), {63'b0, fset}, 64'd1);
      chk($sformatf("g%0d_word", r), word, wexp(ew0, ew1, ew2));
      chk($sformatf("g%0d_mode", r), {60'b0, mode}, {60'b0, tbl[r].mode});
      chk($sformatf("g%0d_or", r), {60'b0, orr}, {60'b0, tbl[r].orr});
      chk($sformatf("g%0d_locked", r), {60'b0, locked}, {60'b0, tbl[r].lk});
      chk($sformatf("g%0d_sat8", r), {word8, mode8, or8, lock8, set8}, {8'd255, 4'b1101});
    end
`ifdef FREQ_MON_IRQ_EN
    chk("irq_pending", {63'b0, irq}, 64'd1);
    irq_test = 1'b1;
    run_gate(6, 314, 200, 1000);
    irq_test = 1'b0;
    @(negedge clk);
    irq_clr = 1'b0;
    ew0 = 6; ew1 = 314; ew2 = 200;
    chk("irq_set_wins", {63'b0, irq}, 64'd1);
    chk("irq_ch2_unlock", {60'b0, locked}, 64'd1);
`endif
    run_gate(50, 92, 150, 500);
    @(negedge clk);
    restart = 1'b0;
    chk("abort_set", {63'b0, fset}, 64'd0);
    chk("abort_locked", {60'b0, locked}, 64'd0);
    chk("abort_word", word, wexp(ew0, ew1, ew2));
    chk("abort_mode_or", {56'b0, mode, orr}, {56'b0, 8'b1110_1010});
    run_gate(40, 92, 205, 1000);
    @(negedge clk);
    chk("post_abort_set", {63'b0, fset}, 64'd1);
    chk("post_abort_word", word, wexp(40, 92, 205));
    chk("post_abort_flags", {52'b0, mode, orr, locked}, {52'b0, 12'b1100_1000_0000});
    run_gate(50, 92, 205, 999);
    @(negedge clk);
    restart = 1'b0;
    chk("term_abort_set", {63'b0, fset}, 64'd0);
    chk("term_abort_word", word, wexp(40, 92, 205));
    run_gate(60, 92, 205, 1000);
    @(negedge clk);
    chk("term_next_set", {63'b0, fset}, 64'd1);
    chk("term_next_word", word, wexp(60, 92, 205));
    chk("term_next_locked", {60'b0, locked}, 64'd0);
    repeat (300) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_word", word, 64'd0);
    chk("midrst_flags", {52'b0, mode, orr, locked}, 64'd0);
    chk("midrst_dut8", {word8, mode8, or8, lock8, set8}, 12'd0);
`ifdef FREQ_MON_IRQ_EN
    chk("midrst_irq", {63'b0, irq}, 64'd0);
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_quiet", {59'b0, fset, mode}, 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
